booth_wallace_mult_12x12: RTL and testbench

//  Pipelined 12x12 signed (two's complement) multiplier, 24-bit product.

---
 rtl/booth_wallace_mult_12x12_if.sv | 25 ++
 rtl/booth_wallace_mult_12x12.sv | 96 +++++++++
 tb/tb_booth_wallace_mult_12x12.sv | 121 ++++++++++++
 3 files changed

// File: rtl/booth_wallace_mult_12x12_if.sv
// Operand/result bundle for the 12x12 Booth/Wallace multiplier.
// The master drives operands and consumes products. The slave is the multiplier.
interface booth_wallace_mult_12x12_if;
    logic        in_valid;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] p;
    logic        p_valid;

    modport master (
        output in_valid,
        output x,
        output y,
        input  p,
        input  p_valid
    );

    modport slave (
        input  in_valid,
        input  x,
        input  y,
        output p,
        output p_valid
    );
endinterface

// File: rtl/booth_wallace_mult_12x12.sv
// Two-stage pipelined 12x12 signed multiplier.
// Radix-4 Booth recoding of y produces six 14-bit partial products of x.
// A three-level 3:2 carry-save tree reduces them, and a 24-bit ripple adder
// produces the final product. One operand pair is accepted every cycle.
module booth_wallace_mult_12x12 (
    input logic                         clk,
    input logic                         rst_n,
    booth_wallace_mult_12x12_if.slave   bus
);

    logic [11:0]       x_r;
    logic [11:0]       y_r;
    logic              v_r;
    logic [12:0]       y_ext;
    logic [13:0]       x_ext;
    logic [13:0]       x_dbl;
    logic [5:0][13:0]  pp;
    logic [5:0][23:0]  spp;
    logic [23:0]       s1, c1, s2, c2, s3, c3, s4, c4;
    logic [23:0]       sum;

    // A 3:2 layer: the carry vector is shifted up one place, and the carry out of bit 23 is dropped.
    function automatic logic [47:0] csa3(input logic [23:0] a, input logic [23:0] b,
                                         input logic [23:0] c);
        logic [23:0] s;
        logic [23:0] maj;
        s   = a ^ b ^ c;
        maj = (a & b) | (a & c) | (b & c);
        return {maj[22:0], 1'b0, s};
    endfunction

    // Stage 1: operands are captured every cycle, whether or not in_valid is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= '0;
            y_r <= '0;
            v_r <= 1'b0;
        end else begin
            x_r <= bus.x;
            y_r <= bus.y;
            v_r <= bus.in_valid;
        end
    end

    // The implicit y[-1] = 0 sits at bit 0 of y_ext.
    assign y_ext = {y_r, 1'b0};
    assign x_ext = {{2{x_r[11]}}, x_r};
    assign x_dbl = {x_ext[12:0], 1'b0};

    // Booth recode each bit triple into a partial product. Negation uses invert+1 over the full 14 bits.
    always_comb begin
        pp  = '0;
        spp = '0;
        for (int i = 0; i < 6; i++) begin
            case (y_ext[2*i +: 3])
                3'b001, 3'b010: pp[i] = x_ext;
                3'b011:         pp[i] = x_dbl;
                3'b100:         pp[i] = ~x_dbl + 14'd1;
                3'b101, 3'b110: pp[i] = ~x_ext + 14'd1;
                default:        pp[i] = '0;
            endcase
            spp[i] = {{10{pp[i][13]}}, pp[i]} << (2 * i);
        end
    end

    // Carry-save reduction tree: 6 -> 4 -> 3 -> 2 rows.
    always_comb begin
        {c1, s1} = csa3(spp[0], spp[1], spp[2]);
        {c2, s2} = csa3(spp[3], spp[4], spp[5]);
        {c3, s3} = csa3(s1, c1, s2);
        {c4, s4} = csa3(c2, s3, c3);
    end

    // Final carry-propagate ripple adder. The result wraps modulo 2^24, which is still exact.
    always_comb begin
        logic carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < 24; i++) begin
            sum[i] = s4[i] ^ c4[i] ^ carry;
            carry  = (s4[i] & c4[i]) | (s4[i] & carry) | (c4[i] & carry);
        end
    end

    // Stage 2: the product follows the stage-1 operands every cycle, and p_valid marks the new ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.p       <= '0;
            bus.p_valid <= 1'b0;
        end else begin
            bus.p       <= sum;
            bus.p_valid <= v_r;
        end
    end

endmodule

// File: tb/tb_booth_wallace_mult_12x12.sv
// Scoreboarded bench for booth_wallace_mult_12x12. The driver pushes x*y,
// computed with plain signed arithmetic, for every valid operand pair. The
// monitor pops one entry and compares it whenever p_valid is seen.
module tb_booth_wallace_mult_12x12;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    logic [23:0] exp_q[$];

    booth_wallace_mult_12x12_if bus ();

    booth_wallace_mult_12x12 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] model_mul(input logic [11:0] a, input logic [11:0] b);
        int prod;
        prod = $signed(a) * $signed(b);
        return prod[23:0];
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [11:0] a, input logic [11:0] b);
        @(negedge clk);
        bus.in_valid = v;
        bus.x        = a;
        bus.y        = b;
        if (v) exp_q.push_back(model_mul(a, b));
    endtask

    // Monitor: on each cycle, a valid product consumes one expected entry.
    initial begin
        logic [23:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && bus.p_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_p_valid: got p=%h with nothing outstanding, required p_valid=0", bus.p);
                end else begin
                    e = exp_q.pop_front();
                    check("product", bus.p, e);
                end
            end
        end
    end

    initial begin
        logic [11:0] dx[10];
        logic [11:0] dy[10];
        dx = '{12'h1FF, 12'h3FF, 12'h7FF, 12'hFFF, 12'h800, 12'h800, 12'h7FF, 12'h000, 12'h5A5, 12'h001};
        dy = '{12'h1FF, 12'h3FF, 12'h7FF, 12'hFFF, 12'h800, 12'h7FF, 12'hFFF, 12'h9C3, 12'h000, 12'h800};
        n_cmp        = 0;
        n_bad        = 0;
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        rst_n        = 1'b1;
        #2 rst_n     = 1'b0;
        #1;
        check("reset_p", bus.p, 24'h0);
        check("reset_p_valid", {23'h0, bus.p_valid}, 24'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Check the spec's fixed values through the scoreboard, and a few literal results directly.
        check("lit_511sq", model_mul(dx[0], dy[0]), 24'h03FC01);
        check("lit_m2048sq", model_mul(dx[4], dy[4]), 24'h400000);
        check("lit_m2048x2047", model_mul(dx[5], dy[5]), 24'hC00800);
        for (int i = 0; i < 10; i++) drive(1'b1, dx[i], dy[i]);

        // Back-to-back operands with in_valid toggling.
        for (int i = 0; i < 40; i++)
            drive(i[0], 12'($urandom), 12'($urandom));

        // Assert reset mid-stream, away from any clock edge.
        drive(1'b1, 12'h1FF, 12'h1FF);
        drive(1'b0, 12'h123, 12'h456);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_p", bus.p, 24'h0);
        check("midreset_p_valid", {23'h0, bus.p_valid}, 24'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep every y with x = -2048, which exercises every Booth digit.
        for (int i = 0; i < 4096; i++) drive(1'b1, 12'h800, 12'(i));

        // Random pairs, with about a quarter of the cycles idle.
        for (int i = 0; i < 50000; i++)
            drive(($urandom % 4) != 0, 12'($urandom), 12'($urandom));

        drive(1'b0, 12'h0, 12'h0);
        drive(1'b0, 12'h0, 12'h0);
        drive(1'b0, 12'h0, 12'h0);
        check("drained", 24'(exp_q.size()), 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
